proc_control_unit: RTL and testbench

- Sequencer for the nine-bit processor.
- Latches each instruction word from DIN into an internal IR and steps it through timesteps T0..T3.
- Drives the bus-select lines (r_out, g_out, DIN_out) into the bus mux, plus register/A/G load enables and the ALU add/sub select.
- Sits directly upstream of the bus mux and the register file.

---
 rtl/proc_pkg.sv | 32 +++
 rtl/dec3to8.sv | 9 +
 rtl/proc_control_unit.sv | 127 ++++++++++++
 tb/tb_proc_control_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the nine-bit processor control path:
// timestep encoding, opcode constants and IR field positions.
package proc_pkg;

  localparam int DATA_W   = 9;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit to 8-bit one-hot decoder used for the X and Y register fields.
module dec3to8 (
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  assign onehot_o = 8'h01 << sel_i;

endmodule

// File: rtl/proc_control_unit.sv
// Instruction sequencer: fetches into IR in T0 and walks T1..T3, driving
// bus-select, load-enable and ALU control lines combinationally.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DATA_W-1:0]   DIN,
  input  logic                g_nonzero,
  output logic                ir_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                g_out,
  output logic                DIN_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                a_in,
  output logic                g_in_en,
  output logic                add_sub,
  output logic                done
);

  tstep_e            step_q, step_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [2:0]        opcode_s;
  logic [7:0]        x_oh_s, y_oh_s;

  assign opcode_s = ir_q[OP_MSB:OP_LSB];

  dec3to8 u_dec_x (.sel_i(ir_q[X_MSB:X_LSB]), .onehot_o(x_oh_s));
  dec3to8 u_dec_y (.sel_i(ir_q[Y_MSB:Y_LSB]), .onehot_o(y_oh_s));

  always_comb begin
    step_d  = step_q;
    ir_d    = ir_q;
    ir_in   = 1'b0;
    r_out   = '0;
    g_out   = 1'b0;
    DIN_out = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in_en = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    // Outputs are forced quiet while reset is held, independent of state.
    if (reset) begin
      step_d = T0;
    end else begin
      case (step_q)
        T0: begin
          if (run) begin
            ir_in  = 1'b1;
            ir_d   = DIN;
            step_d = T1;
          end else begin
            step_d = T0;
          end
        end
        T1: begin
          step_d = T0;
          case (opcode_s)
            OP_MV: begin
              r_out = y_oh_s;
              r_in  = x_oh_s;
              done  = 1'b1;
            end
            OP_MVI: begin
              DIN_out = 1'b1;
              r_in    = x_oh_s;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              r_out  = x_oh_s;
              a_in   = 1'b1;
              step_d = T2;
            end
            OP_MVNZ: begin
              if (g_nonzero) begin
                r_out = y_oh_s;
                r_in  = x_oh_s;
              end else begin
                r_out = '0;
              end
              done = 1'b1;
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          if (is_alu_op(opcode_s)) begin
            r_out   = y_oh_s;
            g_in_en = 1'b1;
            add_sub = opcode_s[0];
            step_d  = T3;
          end else begin
            step_d = T0;
          end
        end
        T3: begin
          step_d = T0;
          if (is_alu_op(opcode_s)) begin
            g_out = 1'b1;
            r_in  = x_oh_s;
            done  = 1'b1;
          end else begin
            done = 1'b0;
          end
        end
        default: step_d = T0;
      endcase
    end
  end

  // Timestep and IR state; IR only moves on a fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed-vector bench: the stimulus pushes one expected output vector per
// cycle into a scoreboard, a negedge monitor pops and compares.
module tb_proc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [8:0] DIN;
  logic       g_nonzero;
  logic       ir_in, g_out, DIN_out, a_in, g_in_en, add_sub, done;
  logic [7:0] r_out, r_in;

  int n_checks = 0;
  int n_fails  = 0;

  logic [22:0] exp_q[$];
  string       name_q[$];

  proc_control_unit dut (
    .clk(clk), .reset(reset), .run(run), .DIN(DIN), .g_nonzero(g_nonzero),
    .ir_in(ir_in), .r_out(r_out), .g_out(g_out), .DIN_out(DIN_out),
    .r_in(r_in), .a_in(a_in), .g_in_en(g_in_en), .add_sub(add_sub),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] mk(input logic ir, input logic [7:0] ro,
                                     input logic go, input logic dout,
                                     input logic [7:0] ri, input logic ai,
                                     input logic gi, input logic as,
                                     input logic dn);
    return {ir, ro, go, dout, ri, ai, gi, as, dn};
  endfunction

  localparam logic [22:0] E_ZERO = 23'd0;
  localparam logic [22:0] E_FETCH = {1'b1, 22'd0};

  task automatic step(input logic rst_v, input logic run_v,
                      input logic [8:0] din_v, input logic gnz_v,
                      input logic [22:0] exp_v, input string nm);
    reset     = rst_v;
    run       = run_v;
    DIN       = din_v;
    g_nonzero = gnz_v;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the full output vector plus the per-cycle invariants.
  always @(negedge clk) begin
    logic [22:0] act, expv;
    string       nm;
    if (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      nm   = name_q.pop_front();
      act  = {ir_in, r_out, g_out, DIN_out, r_in, a_in, g_in_en, add_sub, done};
      n_checks++;
      if (act !== expv) begin
        n_fails++;
        $display("FAIL %s: got ir_in=%b r_out=%h g_out=%b DIN_out=%b r_in=%h a_in=%b g_in=%b add_sub=%b done=%b, want %h (got %h)",
                 nm, ir_in, r_out, g_out, DIN_out, r_in, a_in, g_in_en, add_sub, done, expv, act);
      end
      n_checks++;
      if ((32'(r_out != 8'h00) + 32'(g_out) + 32'(DIN_out)) > 32'd1 ||
          !$onehot0(r_out) || !$onehot0(r_in) || (add_sub && !g_in_en)) begin
        n_fails++;
        $display("FAIL %s invariant: r_out=%h r_in=%h g_out=%b DIN_out=%b add_sub=%b g_in_en=%b, want exclusive bus/one-hot",
                 nm, r_out, r_in, g_out, DIN_out, add_sub, g_in_en);
      end
    end
  end

  localparam logic [8:0] I_ADD13 = 9'b010_001_011;
  localparam logic [8:0] I_MVI2  = 9'b001_010_000;
  localparam logic [8:0] I_MV07  = 9'b000_000_111;
  localparam logic [8:0] I_SUB55 = 9'b011_101_101;
  localparam logic [8:0] I_MVNZ  = 9'b101_100_110;
  localparam logic [8:0] I_NOP7  = 9'b111_010_011;

  initial begin
    reset = 1'b1; run = 1'b0; DIN = 9'd0; g_nonzero = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, I_MV07, 1'b1, E_ZERO, "reset_held");
    step(1'b0, 1'b0, I_MV07, 1'b0, E_ZERO, "idle_after_reset");

    // abort add R1,R3 in T2
    step(1'b0, 1'b1, I_ADD13, 1'b0, E_FETCH, "abort_add_t0");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "abort_add_t1");
    step(1'b1, 1'b0, 9'd0, 1'b0, E_ZERO, "abort_reset_mid_t2");
    step(1'b1, 1'b1, I_ADD13, 1'b0, E_ZERO, "abort_reset_hold");
    step(1'b0, 1'b0, I_ADD13, 1'b0, E_ZERO, "abort_idle_0");
    step(1'b0, 1'b0, I_ADD13, 1'b1, E_ZERO, "abort_idle_1");

    step(1'b0, 1'b1, I_MVI2, 1'b0, E_FETCH, "mvi_t0");
    step(1'b0, 1'b0, 9'h0AB, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1), "mvi_t1");

    step(1'b0, 1'b1, I_MV07, 1'b0, E_FETCH, "mv_t0");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h80, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1), "mv_t1");

    step(1'b0, 1'b1, I_ADD13, 1'b0, E_FETCH, "add_t0");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "add_t1");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), "add_t2");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1), "add_t3");

    step(1'b0, 1'b1, I_SUB55, 1'b0, E_FETCH, "sub_t0");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "sub_t1");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), "sub_t2");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1), "sub_t3");

    step(1'b0, 1'b1, I_MVNZ, 1'b0, E_FETCH, "mvnz0_t0");
    step(1'b0, 1'b0, 9'd0, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), "mvnz0_t1");
    step(1'b0, 1'b1, I_MVNZ, 1'b1, E_FETCH, "mvnz1_t0");
    step(1'b0, 1'b0, 9'd0, 1'b1, mk(1'b0, 8'h40, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1), "mvnz1_t1");

    step(1'b0, 1'b1, I_NOP7, 1'b1, E_FETCH, "nop_t0");
    step(1'b0, 1'b0, 9'd0, 1'b1, mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1), "nop_t1");

    // run held high: ignored in T1..T3, next fetch right after done
    step(1'b0, 1'b1, I_ADD13, 1'b0, E_FETCH, "b2b_add_t0");
    step(1'b0, 1'b1, I_MV07, 1'b0, mk(1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "b2b_add_t1");
    step(1'b0, 1'b1, I_MV07, 1'b0, mk(1'b0, 8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), "b2b_add_t2");
    step(1'b0, 1'b1, I_MV07, 1'b0, mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_add_t3");
    step(1'b0, 1'b1, I_MV07, 1'b0, E_FETCH, "b2b_mv_fetch");
    step(1'b0, 1'b1, I_MVI2, 1'b0, mk(1'b0, 8'h80, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_mv_t1");
    step(1'b0, 1'b1, I_MVI2, 1'b0, E_FETCH, "b2b_mvi_fetch");
    step(1'b0, 1'b0, 9'h155, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_mvi_t1");
    step(1'b0, 1'b0, 9'd0, 1'b0, E_ZERO, "final_idle");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
